// File: rtl/regfile_op_sequencer_if.sv
// Bundles the instruction handshake and the register-file port signals of the
// op sequencer; slave is the sequencer side, master is the upstream/RAM side.
interface regfile_op_sequencer_if #(
  parameter int Width        = 8,
  parameter int AddressWidth = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              in_op;
  logic [AddressWidth-1:0] in_rd;
  logic [AddressWidth-1:0] in_rs1;
  logic [AddressWidth-1:0] in_rs2;
  logic [Width-1:0]        in_imm;
  logic [AddressWidth-1:0] r1addr;
  logic [AddressWidth-1:0] r2addr;
  logic [Width-1:0]        Q1;
  logic [Width-1:0]        Q2;
  logic                    we;
  logic [AddressWidth-1:0] waddr;
  logic [Width-1:0]        D;
  logic                    done;
  logic                    carry;
  logic                    zero;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, Q1, Q2,
    output in_ready, r1addr, r2addr, we, waddr, D, done, carry, zero
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, Q1, Q2,
    input  in_ready, r1addr, r2addr, we, waddr, D, done, carry, zero
  );
endinterface

// File: rtl/regfile_op_sequencer.sv
// Four-cycle read/execute/write-back sequencer driving a 2R1W register file
// with combinational read ports.
//
// state | meaning
// IDLE  | in_ready high, waiting for an instruction
// READ  | read addresses driven, operands captured at end of cycle
// EXEC  | ALU result and flags registered at end of cycle
// WRITE | single we/done pulse with D=result, waddr=rd
module regfile_op_sequencer #(
  parameter int Width        = 8,
  parameter int AddressWidth = 4
) (
  input logic                    clk,
  input logic                    rst,
  regfile_op_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_MOV = 3'd6,
    OP_LDI = 3'd7
  } op_e;

  state_e                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [AddressWidth-1:0] rd_q, rd_d;
  logic [AddressWidth-1:0] rs1_q, rs1_d;
  logic [AddressWidth-1:0] rs2_q, rs2_d;
  logic [Width-1:0]        imm_q, imm_d;
  logic [Width-1:0]        a_q, a_d;
  logic [Width-1:0]        b_q, b_d;
  logic [Width-1:0]        result_q, result_d;
  logic                    carry_q, carry_d;
  logic                    zero_q, zero_d;

  logic                    in_ready;
  logic                    accept;
  logic [Width-1:0]        alu_res;
  logic                    alu_carry;
  logic [Width:0]          ext_sum;
  logic [Width:0]          ext_diff;

  assign accept = in_ready & bus.in_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; gated with rst so a reset cycle never writes or accepts
  always_comb begin
    in_ready = 1'b0;
    bus.we   = 1'b0;
    bus.done = 1'b0;
    if (!rst) begin
      in_ready = (state_q == IDLE);
      bus.we   = (state_q == WRITE);
      bus.done = (state_q == WRITE);
    end
  end

  assign ext_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign ext_diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_e'(op_q))
      OP_ADD: begin
        alu_res   = ext_sum[Width-1:0];
        alu_carry = ext_sum[Width];
      end
      OP_SUB: begin
        alu_res   = ext_diff[Width-1:0];
        alu_carry = ext_diff[Width];
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOT:  alu_res = ~a_q;
      OP_MOV:  alu_res = a_q;
      OP_LDI:  alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  // Datapath next-state: latch on accept, operands in READ, result in EXEC
  always_comb begin
    op_d     = op_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    if (accept) begin
      op_d  = bus.in_op;
      rd_d  = bus.in_rd;
      rs1_d = bus.in_rs1;
      rs2_d = bus.in_rs2;
      imm_d = bus.in_imm;
    end
    if (state_q == READ) begin
      a_d = bus.Q1;
      b_d = bus.Q2;
    end
    if (state_q == EXEC) begin
      result_d = alu_res;
      carry_d  = alu_carry;
      zero_d   = (alu_res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.r1addr   = rs1_q;
  assign bus.r2addr   = rs2_q;
  assign bus.waddr    = rd_q;
  assign bus.D        = result_q;
  assign bus.carry    = carry_q;
  assign bus.zero     = zero_q;

endmodule
